// File: rtl/child_dispatch_rr.sv
// Round-robin work dispatcher: buffers a valid/ready stream in a small FIFO and
// hands each head word to the next child in strict order 0..NUM_CHILDREN-1.
module child_dispatch_rr #(
    parameter int NUM_CHILDREN = 10,
    parameter int DATA_W       = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int IDX_W        = $clog2(NUM_CHILDREN),
    parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    output logic [NUM_CHILDREN-1:0] out_valid,
    input  logic [NUM_CHILDREN-1:0] out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [IDX_W-1:0]        out_idx,
    output logic [CNT_W-1:0]        fifo_count,
    output logic [31:0]             dispatch_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       disp_q, disp_d;

    logic not_empty;
    logic push;
    logic pop;

    // Readiness and validity come only from registered occupancy, so there is
    // no combinational path from in_valid to out_valid.
    always_comb begin
        not_empty = (count_q != '0);
        in_ready  = (count_q != CNT_W'(FIFO_DEPTH));
        push      = in_valid & in_ready;
        pop       = not_empty & out_ready[idx_q];
    end

    always_comb begin
        out_valid = '0;
        for (int unsigned i = 0; i < NUM_CHILDREN; i++) begin
            out_valid[i] = not_empty && (IDX_W'(i) == idx_q);
        end
        out_data       = not_empty ? mem_q[rd_ptr_q] : '0;
        out_idx        = idx_q;
        fifo_count     = count_q;
        dispatch_count = disp_q;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        idx_d    = idx_q;
        disp_d   = disp_q;
        if (flush) begin
            // Same-cycle push/pop are dropped; target index and tally survive.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                idx_d    = (idx_q == IDX_W'(NUM_CHILDREN - 1)) ? '0 : idx_q + IDX_W'(1);
                disp_d   = disp_q + 32'd1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            disp_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            disp_q   <= disp_d;
        end
    end

    // Storage needs no reset: contents are only visible while count is nonzero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_child_dispatch_rr.sv
// Randomized plus directed bench for child_dispatch_rr, checked against a
// queue-based reference model of the dispatcher.
module tb_child_dispatch_rr;

    localparam int N     = 10;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int IW    = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [N-1:0]  out_valid;
    logic [N-1:0]  out_ready = '0;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic [CW-1:0] fifo_count;
    logic [31:0]   dispatch_count;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic [DW-1:0] m_q[$];
    int            m_idx  = 0;
    int unsigned   m_disp = 0;

    child_dispatch_rr #(
        .NUM_CHILDREN(N),
        .DATA_W(DW),
        .FIFO_DEPTH(DEPTH),
        .IDX_W(IW),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_idx(out_idx),
        .fifo_count(fifo_count),
        .dispatch_count(dispatch_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the rules of the dispatcher.
    task automatic model_step(input logic r, input logic f, input logic iv,
                              input logic [DW-1:0] id, input logic [N-1:0] ordy);
        bit do_pop, do_push;
        if (r) begin
            m_q.delete();
            m_idx  = 0;
            m_disp = 0;
        end else if (f) begin
            m_q.delete();
        end else begin
            do_pop  = (m_q.size() != 0) && ordy[m_idx];
            do_push = iv && (m_q.size() != DEPTH);
            if (do_pop) begin
                void'(m_q.pop_front());
                m_idx  = (m_idx + 1) % N;
                m_disp = m_disp + 1;
            end
            if (do_push) m_q.push_back(id);
        end
    endtask

    task automatic check_outputs(input logic was_rst);
        logic [N-1:0] exp_valid;
        exp_valid = '0;
        if (m_q.size() != 0) exp_valid[m_idx] = 1'b1;
        check_val("in_ready", 64'(in_ready), 64'(m_q.size() != DEPTH));
        check_val("out_valid", 64'(out_valid), 64'(exp_valid));
        check_val("fifo_count", 64'(fifo_count), 64'(m_q.size()));
        check_val("out_idx", 64'(out_idx), 64'(m_idx));
        check_val("dispatch_count", 64'(dispatch_count), 64'(m_disp));
        if (m_q.size() != 0) check_val("out_data", 64'(out_data), 64'(m_q[0]));
        if (was_rst) check_val("rst_out_data", 64'(out_data), 64'(0));
    endtask

    task automatic cycle(input logic r, input logic f, input logic iv,
                         input logic [DW-1:0] id, input logic [N-1:0] ordy);
        @(negedge clk);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        @(posedge clk);
        model_step(r, f, iv, id, ordy);
        #1;
        check_outputs(r);
    endtask

    initial begin
        int guard;
        cycle(1'b1, 1'b0, 1'b0, '0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0, '0);

        // Back-to-back pushes, every child ready: each child k receives 1+k
        for (int k = 1; k <= 10; k++) cycle(1'b0, 1'b0, 1'b1, DW'(k), '1);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, '0, '1);
        check_val("seq1_idx", 64'(out_idx), 64'(0));
        check_val("seq1_disp", 64'(dispatch_count), 64'(10));

        // All stalled: six offered, four accepted
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 1'b1, DW'(16'h0100 + k), '0);
        check_val("full_count", 64'(fifo_count), 64'(4));
        check_val("full_ready", 64'(in_ready), 64'(0));
        check_val("full_valid", 64'(out_valid), 64'(10'b0000000001));
        check_val("full_head", 64'(out_data), 64'(16'h0100));

        // One-cycle ready on child 0 while full and in_valid held
        cycle(1'b0, 1'b0, 1'b1, 16'h0200, 10'b0000000001);
        check_val("pop_count", 64'(fifo_count), 64'(3));
        check_val("pop_idx", 64'(out_idx), 64'(1));
        cycle(1'b0, 1'b0, 1'b1, 16'h0201, '0);
        check_val("refill_count", 64'(fifo_count), 64'(4));

        // Drain two to reach child 3, then stall on it
        cycle(1'b0, 1'b0, 1'b0, '0, '1);
        cycle(1'b0, 1'b0, 1'b0, '0, '1);
        check_val("at3_idx", 64'(out_idx), 64'(3));
        cycle(1'b0, 1'b0, 1'b0, '0, 10'b0000010000);
        check_val("wrong_rdy_idx", 64'(out_idx), 64'(3));
        check_val("wrong_rdy_cnt", 64'(fifo_count), 64'(2));
        cycle(1'b0, 1'b0, 1'b0, '0, 10'b0000001000);
        check_val("right_rdy_idx", 64'(out_idx), 64'(4));

        // Refill to 2, then simultaneous push/pop keeps occupancy steady
        cycle(1'b0, 1'b0, 1'b1, 16'h0300, '0);
        for (int k = 1; k <= 8; k++) cycle(1'b0, 1'b0, 1'b1, DW'(16'h0300 + k), '1);
        check_val("steady_count", 64'(fifo_count), 64'(2));

        // Steer to empty with target child 7
        guard = 0;
        while ((m_idx != 7 || m_q.size() != 0) && guard < 100) begin
            if (m_q.size() == 0) cycle(1'b0, 1'b0, 1'b1, DW'($urandom), '0);
            else                 cycle(1'b0, 1'b0, 1'b0, '0, '1);
            guard++;
        end
        check_val("steer_timeout", 64'(guard < 100), 64'(1));
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1, DW'(16'h0400 + k), '0);
        check_val("pre_flush_cnt", 64'(fifo_count), 64'(3));
        cycle(1'b0, 1'b1, 1'b1, 16'h0499, '1);
        check_val("flush_cnt", 64'(fifo_count), 64'(0));
        check_val("flush_valid", 64'(out_valid), 64'(0));
        check_val("flush_idx", 64'(out_idx), 64'(7));
        check_val("flush_ready", 64'(in_ready), 64'(1));
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1, DW'(16'h0500 + k), '0);
        cycle(1'b1, 1'b1, 1'b1, 16'h0599, '1);
        check_val("rst_idx", 64'(out_idx), 64'(0));
        check_val("rst_disp", 64'(dispatch_count), 64'(0));
        check_val("rst_cnt", 64'(fifo_count), 64'(0));

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic [N-1:0] rdy;
            rdy = '0;
            for (int c = 0; c < N; c++) rdy[c] = ($urandom_range(0, 3) != 0);
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 2) != 0), DW'($urandom), rdy);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
